// File: rtl/parking_pkg.sv
// Shared constants and FSM encoding for the parking allocator.
// Imported by the encoder and the top-level controller.
package parking_pkg;

  localparam int NUM_SPACES = 8;
  localparam int SPACE_W    = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    GATE      = 2'd2,
    EXIT_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/free_space_encoder.sv
// Lowest-free-space priority encoder over the occupancy map.
// in: occupancy; out: free_idx (lowest zero bit), any_free.
module free_space_encoder
  import parking_pkg::*;
(
  input  logic [NUM_SPACES-1:0] occupancy,
  output logic [SPACE_W-1:0]    free_idx,
  output logic                  any_free
);

  // Scan high to low so the lowest free index wins.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SPACES - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx = SPACE_W'(i);
      end
    end
  end

  assign any_free = ~&occupancy;

endmodule

// File: rtl/parking_allocator.sv
// Parking controller: occupancy map, entry grant, exit release, gate.
// in: clk, rst, entry_req, exit_req, exit_space; out: acks, gate, status.
module parking_allocator
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  entry_req,
  output logic                  entry_ack,
  output logic [SPACE_W-1:0]    entry_space,
  input  logic                  exit_req,
  input  logic [SPACE_W-1:0]    exit_space,
  output logic                  exit_ack,
  output logic                  exit_err,
  output logic                  gate_open,
  output logic                  full,
  output logic [CNT_W-1:0]      free_count,
  output logic [NUM_SPACES-1:0] occupancy
);

  state_t                  state_q;
  logic [NUM_SPACES-1:0]   occ_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    entry_ack_q;
  logic [SPACE_W-1:0]      entry_space_q;
  logic                    exit_ack_q;
  logic                    exit_err_q;
  logic                    gate_q;

  logic [SPACE_W-1:0]      free_idx;
  logic                    any_free;
  logic [CNT_W-1:0]        free_cnt;

  free_space_encoder u_enc (
    .occupancy (occ_q),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_SPACES; i++) begin
      free_cnt = free_cnt + CNT_W'(~occ_q[i]);
    end
  end

  // GRANT is the first gate cycle; GATE covers the
  // remaining GATE_CYCLES-1, leaving as the count hits 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      cnt_q         <= '0;
      entry_ack_q   <= 1'b0;
      entry_space_q <= '0;
      exit_ack_q    <= 1'b0;
      exit_err_q    <= 1'b0;
      gate_q        <= 1'b0;
    end else begin
      entry_ack_q   <= 1'b0;
      entry_space_q <= '0;
      exit_ack_q    <= 1'b0;
      exit_err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (exit_req) begin
            state_q    <= EXIT_RESP;
            exit_ack_q <= occ_q[exit_space];
            exit_err_q <= ~occ_q[exit_space];
          end else if (entry_req && any_free) begin
            state_q       <= GRANT;
            entry_ack_q   <= 1'b1;
            entry_space_q <= free_idx;
            gate_q        <= 1'b1;
          end
        end
        GRANT: begin
          occ_q[entry_space_q] <= 1'b1;
          cnt_q   <= CNT_W'(GATE_CYCLES - 1);
          state_q <= GATE;
        end
        GATE: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        EXIT_RESP: begin
          if (exit_ack_q) begin
            occ_q[exit_space] <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign entry_ack   = entry_ack_q;
  assign entry_space = entry_space_q;
  assign exit_ack    = exit_ack_q;
  assign exit_err    = exit_err_q;
  assign gate_open   = gate_q;
  assign occupancy   = occ_q;
  assign free_count  = free_cnt;
  assign full        = (occ_q == {NUM_SPACES{1'b1}});

endmodule
